ppl_pixel_sink: RTL and testbench

//  Consumer end of the ray-cast pipeline's pixel output. Takes each valid {pixel_addr, texture_addr}

---
 rtl/ppl_pixel_sink_if.sv | 22 ++
 rtl/ppl_pixel_sink.sv | 84 ++++++++
 tb/tb_ppl_pixel_sink.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ppl_pixel_sink_if.sv
// rtl/ppl_pixel_sink_if.sv - pixel-in, texture ROM and framebuffer write signal bundle
interface ppl_pixel_sink_if;
    logic        in_valid;
    logic [19:0] in_pixel_addr;
    logic [12:0] in_texture_addr;
    logic [12:0] tex_addr;
    logic [15:0] tex_data;
    logic        fb_wr_en;
    logic        fb_wr_ready;
    logic [19:0] fb_wr_addr;
    logic [15:0] fb_wr_data;

    modport slave (
        input  in_valid, in_pixel_addr, in_texture_addr, tex_data, fb_wr_ready,
        output tex_addr, fb_wr_en, fb_wr_addr, fb_wr_data
    );

    modport master (
        output in_valid, in_pixel_addr, in_texture_addr, tex_data, fb_wr_ready,
        input  tex_addr, fb_wr_en, fb_wr_addr, fb_wr_data
    );
endinterface

// File: rtl/ppl_pixel_sink.sv
// rtl/ppl_pixel_sink.sv - texel fetch, pixel FIFO and framebuffer drain with frame accounting
module ppl_pixel_sink #(
    parameter int H_DISP     = 1280,
    parameter int V_DISP     = 720,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_ppl,
    input  logic                          rst,
    ppl_pixel_sink_if.slave               pix,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_done,
    output logic [7:0]                    frame_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [20:0] NUM_PIX   = 21'(H_DISP * V_DISP);
    localparam logic [19:0] LAST_ADDR = 20'(H_DISP * V_DISP - 1);

    logic        s1_valid;
    logic [19:0] s1_addr;

    logic [35:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [35:0] head;

    assign pix.tex_addr = pix.in_texture_addr;

    always_ff @(posedge clk_ppl) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= pix.in_valid && ({1'b0, pix.in_pixel_addr} < NUM_PIX);
            s1_addr  <= pix.in_pixel_addr;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && pix.fb_wr_ready;
    // When full, a same-cycle pop frees the slot this push overwrites; the read port sees the old word.
    assign push  = s1_valid && (!full || pop);

    assign head           = mem[rd_ptr[AW-1:0]];
    assign pix.fb_wr_en   = !empty;
    assign pix.fb_wr_addr = empty ? 20'd0 : head[35:16];
    assign pix.fb_wr_data = empty ? 16'd0 : head[15:0];
    assign fifo_level     = wr_ptr - rd_ptr;

    always_ff @(posedge clk_ppl) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s1_addr, pix.tex_data};
        end
    end

    always_ff @(posedge clk_ppl) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (s1_valid && !push) begin
                overflow <= 1'b1;
            end
            frame_done <= pop && (pix.fb_wr_addr == LAST_ADDR);
            if (pop && (pix.fb_wr_addr == LAST_ADDR)) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_ppl_pixel_sink.sv
// tb/tb_ppl_pixel_sink.sv - directed self-checking bench for ppl_pixel_sink
module tb_ppl_pixel_sink;
    logic       clk_ppl;
    logic       rst;
    logic [4:0] fifo_level;
    logic       overflow;
    logic       frame_done;
    logic [7:0] frame_cnt;

    int checks;
    int errors;

    logic [19:0] wa_q [$];
    logic [15:0] wd_q [$];

    ppl_pixel_sink_if pix ();

    ppl_pixel_sink #(.H_DISP(1280), .V_DISP(720), .FIFO_DEPTH(16)) dut (
        .clk_ppl    (clk_ppl),
        .rst        (rst),
        .pix        (pix),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    initial clk_ppl = 1'b0;
    always #5 clk_ppl = ~clk_ppl;

    function automatic logic [15:0] rom(input logic [12:0] a);
        if (a == 13'h10) return 16'hF800;
        return {3'b000, a} ^ 16'hA5C3;
    endfunction

    always @(posedge clk_ppl) pix.tex_data <= rom(pix.tex_addr);

    // Inputs only change 1 time unit after a rising edge, so the negedge sees what the next edge will.
    always @(negedge clk_ppl) begin
        if (rst && pix.fb_wr_en && pix.fb_wr_ready) begin
            wa_q.push_back(pix.fb_wr_addr);
            wd_q.push_back(pix.fb_wr_data);
        end
    end

    task automatic tick();
        @(posedge clk_ppl);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [19:0] a, input logic [12:0] t);
        pix.in_valid        = 1'b1;
        pix.in_pixel_addr   = a;
        pix.in_texture_addr = t;
        tick();
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int maxl;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        pix.in_valid = 1'b0;
        pix.in_pixel_addr = '0;
        pix.in_texture_addr = '0;
        pix.fb_wr_ready = 1'b0;
        pix.tex_data = '0;
        repeat (3) tick();

        check("rst_wr_en", pix.fb_wr_en, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_wr_addr", pix.fb_wr_addr, 0);
        check("rst_wr_data", pix.fb_wr_data, 0);
        rst = 1'b1;
        tick();

        // single pixel latency and hold while not ready
        clear_log();
        pix.in_valid = 1'b1;
        pix.in_pixel_addr = 20'd5;
        pix.in_texture_addr = 13'h10;
        check("t1_tex_addr", pix.tex_addr, 32'h10);
        tick();
        pix.in_valid = 1'b0;
        check("t1_en_n1", pix.fb_wr_en, 0);
        tick();
        check("t1_en_n2", pix.fb_wr_en, 1);
        check("t1_addr", pix.fb_wr_addr, 5);
        check("t1_data", pix.fb_wr_data, 32'hF800);
        tick();
        check("t1_hold_addr", pix.fb_wr_addr, 5);
        check("t1_hold_data", pix.fb_wr_data, 32'hF800);
        pix.fb_wr_ready = 1'b1;
        tick();
        check("t1_drained", pix.fb_wr_en, 0);
        check("t1_writes", wa_q.size(), 1);

        // full rate streaming
        clear_log();
        maxl = 0;
        for (int i = 0; i < 100; i++) begin
            drive(20'(i), 13'(i));
            if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
        end
        pix.in_valid = 1'b0;
        repeat (4) tick();
        check("t2_writes", wa_q.size(), 100);
        bad = 0;
        for (int i = 0; i < 100 && i < wa_q.size(); i++)
            if (wa_q[i] !== 20'(i) || wd_q[i] !== rom(13'(i))) bad++;
        check("t2_order", bad, 0);
        check("t2_max_level_le1", maxl <= 1, 1);
        check("t2_overflow", overflow, 0);

        // overflow with stalled framebuffer
        clear_log();
        pix.fb_wr_ready = 1'b0;
        for (int i = 0; i < 20; i++) drive(20'(i), 13'(i + 100));
        pix.in_valid = 1'b0;
        repeat (2) tick();
        check("t3_level_full", fifo_level, 16);
        check("t3_overflow", overflow, 1);
        check("t3_head_addr", pix.fb_wr_addr, 0);
        pix.fb_wr_ready = 1'b1;
        repeat (20) tick();
        check("t3_writes", wa_q.size(), 16);
        bad = 0;
        for (int i = 0; i < 16 && i < wa_q.size(); i++)
            if (wa_q[i] !== 20'(i) || wd_q[i] !== rom(13'(i + 100))) bad++;
        check("t3_order", bad, 0);
        check("t3_overflow_sticky", overflow, 1);
        check("t3_level_empty", fifo_level, 0);

        // push and pop together while full
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t4_overflow_cleared", overflow, 0);
        clear_log();
        pix.fb_wr_ready = 1'b0;
        for (int i = 0; i < 17; i++) drive(20'(200 + i), 13'(i));
        pix.in_valid = 1'b0;
        check("t4_level_pre", fifo_level, 16);
        pix.fb_wr_ready = 1'b1;
        tick();
        pix.fb_wr_ready = 1'b0;
        check("t4_level_post", fifo_level, 16);
        check("t4_overflow", overflow, 0);
        check("t4_head_addr", pix.fb_wr_addr, 201);
        pix.fb_wr_ready = 1'b1;
        repeat (20) tick();
        check("t4_writes", wa_q.size(), 17);
        bad = 0;
        for (int i = 0; i < 17 && i < wa_q.size(); i++)
            if (wa_q[i] !== 20'(200 + i) || wd_q[i] !== rom(13'(i))) bad++;
        check("t4_order", bad, 0);

        // frame completion and out-of-range address
        clear_log();
        drive(20'd921599, 13'd7);
        pix.in_valid = 1'b0;
        check("t5_fd_n1", frame_done, 0);
        tick();
        check("t5_en_n2", pix.fb_wr_en, 1);
        check("t5_fd_n2", frame_done, 0);
        tick();
        check("t5_fd_pulse", frame_done, 1);
        check("t5_frame_cnt1", frame_cnt, 1);
        tick();
        check("t5_fd_low", frame_done, 0);
        check("t5_frame_cnt_hold", frame_cnt, 1);
        drive(20'd921600, 13'd8);
        pix.in_valid = 1'b0;
        repeat (4) tick();
        check("t5_oob_no_write", wa_q.size(), 1);
        check("t5_oob_en", pix.fb_wr_en, 0);
        check("t5_oob_overflow", overflow, 0);
        drive(20'd921599, 13'd9);
        pix.in_valid = 1'b0;
        repeat (4) tick();
        check("t5_frame_cnt2", frame_cnt, 2);

        // reset with buffered pixels
        pix.fb_wr_ready = 1'b0;
        for (int i = 0; i < 9; i++) drive(20'(300 + i), 13'(i));
        pix.in_valid = 1'b0;
        repeat (2) tick();
        check("t6_level9", fifo_level, 9);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t6_level", fifo_level, 0);
        check("t6_en", pix.fb_wr_en, 0);
        check("t6_overflow", overflow, 0);
        check("t6_frame_cnt", frame_cnt, 0);
        check("t6_addr", pix.fb_wr_addr, 0);
        clear_log();
        pix.fb_wr_ready = 1'b1;
        repeat (5) tick();
        check("t6_no_stale", wa_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
